// File: rtl/tx_frame_sequencer.sv
// Arbitrates two byte-stream requesters onto one transmitter and optionally appends CRC_A.
// Exposes the FSM state on state_dbg for observation.
module tx_frame_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       r0_valid,
  input  logic [7:0] r0_data,
  input  logic       r0_last,
  input  logic [2:0] r0_last_bits,
  input  logic       r0_append_crc,
  output logic       r0_ready,
  input  logic       r1_valid,
  input  logic [7:0] r1_data,
  input  logic       r1_last,
  input  logic [2:0] r1_last_bits,
  input  logic       r1_append_crc,
  output logic       r1_ready,
  input  logic       fdt_trigger,
  input  logic       tx_req,
  output logic [7:0] data,
  output logic [2:0] data_bits,
  output logic       ready_to_send,
  output logic       busy,
  output logic       grant,
  output logic       frame_done,
  output logic       underrun,
  output logic [2:0] state_dbg
);

  // Handshake: a requester holds valid and its byte fields stable until it sees
  // its rn_ready high at a clock edge; that edge pops the byte. rn_ready is a
  // one-cycle strobe issued in the cycle after the byte was captured.

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    WAIT_START = 3'd2,
    STREAM     = 3'd3,
    CRC_LO     = 3'd4,
    CRC_HI     = 3'd5,
    FINISH     = 3'd6
  } state_t;

  localparam logic [15:0] CRC_PRESET = 16'h6363;

  state_t      state;
  logic        last_ptr;
  logic        cur_last;
  logic        crc_en;
  logic [15:0] crc;

  logic        sel_valid;
  logic [7:0]  sel_data;
  logic        sel_last;
  logic [2:0]  sel_last_bits;
  logic        sel_append_crc;
  logic        winner;
  logic [2:0]  load_bits;
  logic        load_crc_en;

  function automatic logic [15:0] crc_a_byte(input logic [15:0] crc_in, input logic [7:0] b);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

  always_comb begin
    sel_valid      = r0_valid;
    sel_data       = r0_data;
    sel_last       = r0_last;
    sel_last_bits  = r0_last_bits;
    sel_append_crc = r0_append_crc;
    if (grant) begin
      sel_valid      = r1_valid;
      sel_data       = r1_data;
      sel_last       = r1_last;
      sel_last_bits  = r1_last_bits;
      sel_append_crc = r1_append_crc;
    end
  end

  // On a tie the requester that was not served last wins.
  always_comb begin
    winner = r1_valid;
    if (r0_valid && r1_valid) winner = ~last_ptr;
  end

  // A short last byte cannot carry a CRC, so append_crc is dropped in that case.
  always_comb begin
    load_bits   = sel_last ? sel_last_bits : 3'd0;
    load_crc_en = sel_last && sel_append_crc && (sel_last_bits == 3'd0);
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_ptr      <= 1'b1;
      cur_last      <= 1'b0;
      crc_en        <= 1'b0;
      crc           <= CRC_PRESET;
      data          <= 8'h00;
      data_bits     <= 3'd0;
      ready_to_send <= 1'b0;
      busy          <= 1'b0;
      grant         <= 1'b0;
      frame_done    <= 1'b0;
      underrun      <= 1'b0;
      r0_ready      <= 1'b0;
      r1_ready      <= 1'b0;
    end else begin
      r0_ready   <= 1'b0;
      r1_ready   <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (r0_valid || r1_valid) begin
            grant <= winner;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          data          <= sel_data;
          data_bits     <= load_bits;
          cur_last      <= sel_last;
          crc_en        <= load_crc_en;
          crc           <= crc_a_byte(CRC_PRESET, sel_data);
          r0_ready      <= ~grant;
          r1_ready      <= grant;
          ready_to_send <= 1'b1;
          state         <= WAIT_START;
        end
        WAIT_START: begin
          if (fdt_trigger) state <= STREAM;
        end
        STREAM: begin
          if (tx_req) begin
            if (!cur_last) begin
              if (sel_valid) begin
                data      <= sel_data;
                data_bits <= load_bits;
                cur_last  <= sel_last;
                crc_en    <= load_crc_en;
                crc       <= crc_a_byte(crc, sel_data);
                r0_ready  <= ~grant;
                r1_ready  <= grant;
              end else begin
                underrun      <= 1'b1;
                frame_done    <= 1'b1;
                ready_to_send <= 1'b0;
                state         <= FINISH;
              end
            end else if (crc_en) begin
              data      <= crc[7:0];
              data_bits <= 3'd0;
              state     <= CRC_LO;
            end else begin
              ready_to_send <= 1'b0;
              frame_done    <= 1'b1;
              state         <= FINISH;
            end
          end
        end
        CRC_LO: begin
          if (tx_req) begin
            data  <= crc[15:8];
            state <= CRC_HI;
          end
        end
        CRC_HI: begin
          if (tx_req) begin
            ready_to_send <= 1'b0;
            frame_done    <= 1'b1;
            state         <= FINISH;
          end
        end
        FINISH: begin
          last_ptr <= grant;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Directed bench for tx_frame_sequencer: requester models, transmitter driver,
// and a monitor that checks presented bytes and frame endings against queues.
module tb_tx_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r0_valid, r0_last, r0_append_crc, r0_ready;
  logic [7:0] r0_data;
  logic [2:0] r0_last_bits;
  logic       r1_valid, r1_last, r1_append_crc, r1_ready;
  logic [7:0] r1_data;
  logic [2:0] r1_last_bits;
  logic       fdt_trigger, tx_req;
  logic [7:0] data;
  logic [2:0] data_bits;
  logic       ready_to_send, busy, grant, frame_done, underrun;
  logic [2:0] state_dbg;

  tx_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_data(r0_data), .r0_last(r0_last),
    .r0_last_bits(r0_last_bits), .r0_append_crc(r0_append_crc), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_data(r1_data), .r1_last(r1_last),
    .r1_last_bits(r1_last_bits), .r1_append_crc(r1_append_crc), .r1_ready(r1_ready),
    .fdt_trigger(fdt_trigger), .tx_req(tx_req),
    .data(data), .data_bits(data_bits), .ready_to_send(ready_to_send),
    .busy(busy), .grant(grant), .frame_done(frame_done), .underrun(underrun),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [12:0] src0_q[$];
  logic [12:0] src1_q[$];
  logic [10:0] exp_q[$];
  logic [1:0]  done_q[$];
  bit          stall0 = 1'b0;
  bit          armed  = 1'b0;
  int          n_vec  = 0;
  int          n_err  = 0;
  int          rdy0_cnt = 0;
  int          rdy1_cnt = 0;

  function automatic logic [12:0] ent(input logic [7:0] d, input logic last,
                                      input logic [2:0] lb, input logic crc);
    return {crc, lb, last, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event, expected none at %0t", name, $time);
  endtask

  task automatic drive_src();
    {r0_append_crc, r0_last_bits, r0_last, r0_data} = 13'd0;
    {r1_append_crc, r1_last_bits, r1_last, r1_data} = 13'd0;
    r0_valid = (src0_q.size() > 0) && !stall0;
    r1_valid = (src1_q.size() > 0);
    if (src0_q.size() > 0) {r0_append_crc, r0_last_bits, r0_last, r0_data} = src0_q[0];
    if (src1_q.size() > 0) {r1_append_crc, r1_last_bits, r1_last, r1_data} = src1_q[0];
  endtask

  // requester models: pop the front byte when the ready strobe is seen
  initial begin
    forever begin
      @(negedge clk);
      if (r0_ready && src0_q.size() > 0) void'(src0_q.pop_front());
      if (r1_ready && src1_q.size() > 0) void'(src1_q.pop_front());
      drive_src();
    end
  end

  // monitor
  initial begin
    logic [10:0] eb;
    logic [1:0]  ed;
    forever begin
      @(negedge clk);
      if (r0_ready) rdy0_cnt++;
      if (r1_ready) rdy1_cnt++;
      if (tx_req && armed && ready_to_send) begin
        if (exp_q.size() == 0) fail_event("unexpected_byte");
        else begin
          eb = exp_q.pop_front();
          check("byte_data_bits", 32'({data, data_bits}), 32'(eb));
        end
      end
      if (frame_done) begin
        if (done_q.size() == 0) fail_event("unexpected_frame_done");
        else begin
          ed = done_q.pop_front();
          check("frame_end_grant_underrun", 32'({grant, underrun}), 32'(ed));
        end
      end
    end
  end

  // driver tasks
  task automatic pulse_tx();
    @(posedge clk); #1 tx_req = 1'b1;
    @(posedge clk); #1 tx_req = 1'b0;
  endtask

  task automatic pulse_fdt();
    @(posedge clk); #1 fdt_trigger = 1'b1;
    @(posedge clk); #1 fdt_trigger = 1'b0;
  endtask

  task automatic wait_rts();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (ready_to_send) seen = 1'b1;
    end
    if (!seen) check("wait_ready_to_send_timeout", 32'(ready_to_send), 32'd1);
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    if (!seen) check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic xmit(input int n, input bit early, input int stall_at);
    wait_rts();
    if (early) pulse_tx();
    pulse_fdt();
    armed = 1'b1;
    for (int k = 0; k < n; k++) begin
      repeat (2) @(posedge clk);
      if (k == stall_at) begin
        #1 stall0 = 1'b1;
        drive_src();
      end
      pulse_tx();
      @(negedge clk);
      check("ready_to_send_after_tx_req", 32'(ready_to_send), 32'(k < n - 1));
    end
    armed = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 32'(data), 32'h00);
    check({tag, "_data_bits"}, 32'(data_bits), 32'd0);
    check({tag, "_flags"},
          32'({ready_to_send, busy, grant, frame_done, underrun, r0_ready, r1_ready}), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  initial begin
    int c0, c1;
    rst_n = 1'b0;
    fdt_trigger = 1'b0;
    tx_req = 1'b0;
    drive_src();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;

    // two-byte frame from r0, no CRC
    exp_q.push_back({8'h93, 3'd0}); exp_q.push_back({8'h20, 3'd0});
    done_q.push_back(2'b00);
    c0 = rdy0_cnt; c1 = rdy1_cnt;
    src0_q.push_back(ent(8'h93, 1'b0, 3'd0, 1'b0));
    src0_q.push_back(ent(8'h20, 1'b1, 3'd0, 1'b0));
    drive_src();
    xmit(2, 1'b0, -1);
    wait_idle();
    check("r0_ready_pulses_frame1", 32'(rdy0_cnt - c0), 32'd2);
    check("r1_ready_pulses_frame1", 32'(rdy1_cnt - c1), 32'd0);

    // r1 frame with CRC_A; early tx_req before the delay timer must be ignored
    exp_q.push_back({8'h50, 3'd0}); exp_q.push_back({8'h00, 3'd0});
    exp_q.push_back({8'h57, 3'd0}); exp_q.push_back({8'hCD, 3'd0});
    done_q.push_back(2'b10);
    c0 = rdy0_cnt; c1 = rdy1_cnt;
    src1_q.push_back(ent(8'h50, 1'b0, 3'd0, 1'b1));
    src1_q.push_back(ent(8'h00, 1'b1, 3'd0, 1'b1));
    drive_src();
    xmit(4, 1'b1, -1);
    wait_idle();
    check("r0_ready_pulses_frame2", 32'(rdy0_cnt - c0), 32'd0);
    check("r1_ready_pulses_frame2", 32'(rdy1_cnt - c1), 32'd2);

    // round-robin after a fresh reset
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    for (int round = 0; round < 2; round++) begin
      logic [7:0] b0, b1;
      b0 = (round == 0) ? 8'hA5 : 8'h01;
      b1 = (round == 0) ? 8'h3C : 8'h02;
      exp_q.push_back({b0, 3'd0}); exp_q.push_back({b1, 3'd0});
      done_q.push_back(2'b00); done_q.push_back(2'b10);
      src0_q.push_back(ent(b0, 1'b1, 3'd0, 1'b0));
      src1_q.push_back(ent(b1, 1'b1, 3'd0, 1'b0));
      drive_src();
      xmit(1, 1'b0, -1);
      xmit(1, 1'b0, -1);
      wait_idle();
    end

    // short last byte: CRC request dropped, data_bits carries 7
    exp_q.push_back({8'h26, 3'd7});
    done_q.push_back(2'b00);
    src0_q.push_back(ent(8'h26, 1'b1, 3'd7, 1'b1));
    drive_src();
    xmit(1, 1'b0, -1);
    wait_idle();

    // underrun: r0 stops offering bytes before the 2nd tx_req
    exp_q.push_back({8'h11, 3'd0}); exp_q.push_back({8'h22, 3'd0});
    done_q.push_back(2'b01);
    c0 = rdy0_cnt;
    src0_q.push_back(ent(8'h11, 1'b0, 3'd0, 1'b0));
    src0_q.push_back(ent(8'h22, 1'b0, 3'd0, 1'b0));
    src0_q.push_back(ent(8'h33, 1'b1, 3'd0, 1'b0));
    drive_src();
    xmit(2, 1'b0, 1);
    wait_idle();
    check("r0_ready_pulses_underrun", 32'(rdy0_cnt - c0), 32'd2);
    src0_q.delete();
    stall0 = 1'b0;
    drive_src();

    // reset while the CRC low byte is presented
    exp_q.push_back({8'h50, 3'd0}); exp_q.push_back({8'h00, 3'd0});
    src1_q.push_back(ent(8'h50, 1'b0, 3'd0, 1'b1));
    src1_q.push_back(ent(8'h00, 1'b1, 3'd0, 1'b1));
    drive_src();
    wait_rts();
    pulse_fdt();
    armed = 1'b1;
    for (int k = 0; k < 2; k++) begin
      repeat (2) @(posedge clk);
      pulse_tx();
    end
    @(negedge clk);
    check("crc_lo_presented", 32'(data), 32'h57);
    @(posedge clk); #1 rst_n = 1'b0;
    armed = 1'b0;
    src1_q.delete();
    drive_src();
    #1 check_reset_outputs("midframe_reset");
    repeat (3) @(posedge clk); #1 rst_n = 1'b1;

    // normal frame after the abandoned one
    exp_q.push_back({8'h93, 3'd0}); exp_q.push_back({8'h20, 3'd0});
    done_q.push_back(2'b00);
    src0_q.push_back(ent(8'h93, 1'b0, 3'd0, 1'b0));
    src0_q.push_back(ent(8'h20, 1'b1, 3'd0, 1'b0));
    drive_src();
    xmit(2, 1'b0, -1);
    wait_idle();

    repeat (5) @(negedge clk);
    check("byte_queue_drained", 32'(exp_q.size()), 32'd0);
    check("frame_queue_drained", 32'(done_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tx_frame_sequencer.md
TX_FRAME_SEQUENCER -- requirements
Module: tx_frame_sequencer

Interface
REQ-001 SHALL have ports: clk  input  1  13.56 MHz clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-002 SHALL have, per requester n in {0,1}: rn_valid  input  1  byte available; rn_data  input  8  byte, LSb sent first; rn_last  input  1  byte is the last of the frame; rn_last_bits  input  3  bits in the last byte, 0 means 8; rn_append_crc  input  1  append CRC_A; rn_ready  output  1  one-cycle pop strobe.
REQ-003 SHALL have transmitter-side ports: fdt_trigger  input  1  frame delay timer fired; tx_req  input  1  transmitter requests the next byte; data  output  8; data_bits  output  3; ready_to_send  output  1.
REQ-004 SHALL have status ports: busy  output  1; grant  output  1  index of the owning requester; frame_done  output  1  pulse; underrun  output  1  pulse.

Function
REQ-005 SHALL implement states IDLE, LOAD, WAIT_START, STREAM, CRC_LO, CRC_HI, FINISH.
REQ-006 IDLE: when any rn_valid=1, SHALL grant round-robin: the requester not granted last wins a tie; the last-granted pointer resets to 1, so r0 wins the first tie; grant updates and the FSM enters LOAD next cycle.
REQ-007 Grant SHALL remain locked until FINISH; the other requester's valid is ignored meanwhile.
REQ-008 LOAD: SHALL copy the granted byte into the data register, pulse rn_ready for exactly one cycle, set ready_to_send=1 and enter WAIT_START.
REQ-009 data_bits SHALL be 0 for non-last bytes and CRC bytes, and rn_last_bits for the last byte when no CRC is appended.
REQ-010 WAIT_START: SHALL hold data/ready_to_send stable; fdt_trigger moves the FSM to STREAM; tx_req before fdt_trigger SHALL be ignored.
REQ-011 STREAM, on tx_req with the current byte not last: if the granted rn_valid=1 in that same cycle, SHALL load the next byte and pulse rn_ready in the following cycle.
REQ-012 STREAM, on tx_req with rn_valid=0 (current byte not last): SHALL pulse underrun, clear ready_to_send and enter FINISH.
REQ-013 STREAM, on tx_req with the current byte last: if append_crc=1 and last_bits=0, SHALL present CRC low byte and enter CRC_LO; otherwise SHALL clear ready_to_send and enter FINISH.
REQ-014 append_crc and last_bits SHALL be sampled when the last byte is loaded; append_crc with last_bits!=0 SHALL be ignored (no CRC sent).
REQ-015 CRC_A SHALL follow ISO/IEC 14443-3: preset 0x6363, reflected polynomial 0x8408, bytes processed LSb first, no final inversion; the CRC is reset at LOAD and updated by each data byte as it is loaded.
REQ-016 CRC_LO on tx_req SHALL present CRC[15:8] and enter CRC_HI; CRC_HI on tx_req SHALL clear ready_to_send and enter FINISH.
REQ-017 FINISH SHALL pulse frame_done for one cycle, including after underrun; the FSM then returns to IDLE with the last-granted pointer updated.
REQ-018 data and data_bits SHALL change only in LOAD or the cycle after a tx_req; they SHALL be register outputs with no combinational path from any input.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 rn_ready SHALL never pulse for the non-granted requester, and never more than once per tx_req.

Reset
REQ-021 While rst_n=0, SHALL force state IDLE, ready_to_send=0, data=0x00, data_bits=0, r0_ready=r1_ready=0, busy=0, grant=0, frame_done=0, underrun=0, CRC=0x6363 and last-granted pointer=1.
REQ-022 Reset mid-frame SHALL abandon the frame without any frame_done or underrun pulse.
REQ-023 The first clk edge after deassertion SHALL behave as IDLE with no residual pop pending.

Verification
REQ-024 r0 frame {0x93, 0x20} with last=1 on 0x20, crc=0 -> data 0x93 then 0x20; ready_to_send drops at the 2nd tx_req; one frame_done; r0_ready pulses twice.
REQ-025 r1 frame {0x50, 0x00} with crc=1 -> bytes 0x50, 0x00, 0x57, 0xCD (CRC_A of 50 00 = 0xCD57); frame_done after the 4th tx_req.
REQ-026 r0 and r1 valid in the same cycle after reset -> r0 granted first, r1 next frame; then both again -> r0 (round-robin).
REQ-027 r0 single byte 0x26 with last_bits=7 and crc=1 -> data_bits=7, no CRC bytes, ready_to_send=0 after the 1st tx_req.
REQ-028 r0_valid drops before the 2nd tx_req of a 3-byte frame -> underrun pulse, ready_to_send=0, frame_done, return to IDLE.
REQ-029 rst_n asserted in CRC_LO -> all outputs at reset values immediately, no frame_done; a new frame afterwards completes normally.
